// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receive path.
//   rx_state_e  : receiver FSM states, encodings held at their legacy values
//   FRAME_BITS  : start + data + parity + stop
//   DATA_BITS   : payload width
//   even_parity : parity check over a data byte plus its parity bit
package uart_rx_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Returns 1 when data plus parity bit holds an odd number of ones.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, oversample strobe and received-byte signals.
//   rx         : serial line, idle high
//   tick       : oversample strobe, one clk wide
//   data_out   : last received byte
//   rx_done    : one-cycle pulse, data_out and error flags valid
//   parity_err : parity mismatch of the last frame
//   frame_err  : stop bit of the last frame sampled 0
//   busy       : receiver not idle
// Modports: slave = the receiver, master = line driver / byte consumer.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                 rx;
  logic                 tick;
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  rx, tick,
    output data_out, rx_done, parity_err, frame_err, busy
  );

  modport master (
    output rx, tick,
    input  data_out, rx_done, parity_err, frame_err, busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep metastability synchroniser for the rx line.
// Flops reset to 1 so an idle line is not mistaken for a start bit after reset.
//   clk   : system clock
//   rst_n : asynchronous reset, active low
//   d_i   : asynchronous input
//   q_o   : synchronised output
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Deserialises start, 8 data bits LSB-first, even
// parity and stop; oversamples the synchronised line on the tick strobe and
// reports each byte with a one-cycle rx_done plus parity/framing flags.
//   clk   : system clock, posedge
//   rst_n : asynchronous reset, active low
//   bus   : uart_rx_if.slave (rx, tick in; data_out, rx_done, parity_err,
//           frame_err, busy out)
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int unsigned    SW     = $clog2(OVERSAMPLE);
  localparam int unsigned    BW     = $clog2(DATA_BITS);
  localparam logic [SW-1:0]  S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]  S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        b_cnt_q, b_cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 brk_q, brk_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (bus.rx),
    .q_o  (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    b_cnt_d = b_cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    brk_d   = brk_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    if (bus.tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            s_cnt_d = '0;
            state_d = START;
          end
        end

        START: begin
          if (s_cnt_q == S_MID) begin
            if (!rx_s) begin
              s_cnt_d = '0;
              b_cnt_d = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end

        DATA: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            sh_d    = {rx_s, sh_q[DATA_BITS-1:1]};
            if (b_cnt_q == B_LAST) begin
              state_d = PARITY;
            end else begin
              b_cnt_d = b_cnt_q + BW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end

        PARITY: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end

        STOP: begin
          // brk_q splits STOP into "waiting for the stop sample" and
          // "line held low after a break", so the break hold never re-reports.
          if (brk_q) begin
            if (rx_s) begin
              brk_d   = 1'b0;
              state_d = IDLE;
            end
          end else if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            data_d  = sh_q;
            perr_d  = even_parity(sh_q, par_q);
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              brk_d = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end

        default: begin
          state_d = IDLE;
          brk_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      b_cnt_q <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      b_cnt_q <= b_cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.rx_done    = done_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus pushes the expected
// byte/flags for each frame it sends; a monitor pops on every rx_done.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned OS = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  uart_rx_if u_if();

  uart_rx #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if.slave)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int unsigned done_times[$];
  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned cyc       = 0;
  int unsigned tick_div  = 1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Tick strobe: every tick_div-th clock, changed away from the active edge.
  initial begin
    int unsigned ph;
    ph = 0;
    u_if.tick = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1 >= tick_div) ? 0 : ph + 1;
      u_if.tick = (ph == 0);
    end
  end

  // Monitor: compares every rx_done against the scoreboard head.
  initial begin
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.rx_done === 1'b1) begin
        check("done_gap", {31'd0, prev}, 32'd0);
        done_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", {24'd0, u_if.data_out}, {24'd0, e.data});
          check("parity_err", {31'd0, u_if.parity_err}, {31'd0, e.perr});
          check("frame_err", {31'd0, u_if.frame_err}, {31'd0, e.ferr});
        end
      end
      prev = u_if.rx_done;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop,
                            input int unsigned bclk);
    logic [FRAME_BITS-1:0] fr;
    fr = {stop, (^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) begin
      u_if.rx = fr[i];
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name, input int unsigned bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    int unsigned n;
    logic [7:0]  aborted;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic [7:0]  ab;

    rst_n   = 1'b0;
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, u_if.data_out}, 32'd0);
    check("rst_rx_done", {31'd0, u_if.rx_done}, 32'd0);
    check("rst_parity_err", {31'd0, u_if.parity_err}, 32'd0);
    check("rst_frame_err", {31'd0, u_if.frame_err}, 32'd0);
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: clean frame 0x03
    n = done_times.size();
    exp_q.push_back('{data: 8'h03, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h03, 1'b0, 1'b1, OS);
    wait_drain("t1_drain", 100);
    check("t1_done_count", done_times.size() - n, 32'd1);

    // 2: 0xA5 with wrong parity bit
    exp_q.push_back('{data: 8'hA5, perr: 1'b1, ferr: 1'b0});
    send_frame(8'hA5, 1'b1, 1'b1, OS);
    wait_drain("t2_drain", 100);

    // 3: 0x3C with stop=0, line held low until 40 clk into the stop bit
    n = done_times.size();
    exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b1});
    send_frame(8'h3C, 1'b0, 1'b0, OS);
    repeat (22) @(negedge clk);
    check("t3_break_busy", {31'd0, u_if.busy}, 32'd1);
    repeat (2) @(negedge clk);
    check("t3_busy_before_release", {31'd0, u_if.busy}, 32'd1);
    u_if.rx = 1'b1;
    for (int i = 0; i < 6 && u_if.busy === 1'b1; i++) @(negedge clk);
    check("t3_busy_released", {31'd0, u_if.busy}, 32'd0);
    wait_drain("t3_drain", 10);
    check("t3_done_count", done_times.size() - n, 32'd1);

    // 4: 4-clk glitch rejected
    repeat (10) @(negedge clk);
    n = done_times.size();
    u_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_glitch_busy", {31'd0, u_if.busy}, 32'd1);
    u_if.rx = 1'b1;
    for (int i = 0; i < 8 && u_if.busy === 1'b1; i++) @(negedge clk);
    check("t4_busy_dropped", {31'd0, u_if.busy}, 32'd0);
    repeat (30) @(negedge clk);
    check("t4_no_done", done_times.size() - n, 32'd0);

    // 5: reset during data bit 4, then clean 0x81
    n  = done_times.size();
    ab = 8'h5A;
    u_if.rx = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      u_if.rx = ab[i];
      repeat (OS) @(negedge clk);
    end
    u_if.rx = ab[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_data_out", {24'd0, u_if.data_out}, 32'd0);
    check("t5_rst_rx_done", {31'd0, u_if.rx_done}, 32'd0);
    check("t5_rst_parity_err", {31'd0, u_if.parity_err}, 32'd0);
    check("t5_rst_frame_err", {31'd0, u_if.frame_err}, 32'd0);
    check("t5_rst_busy", {31'd0, u_if.busy}, 32'd0);
    u_if.rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_done_aborted", done_times.size() - n, 32'd0);
    exp_q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h81, 1'b0, 1'b1, OS);
    wait_drain("t5_drain", 100);
    check("t5_done_count", done_times.size() - n, 32'd1);

    // 6: back-to-back 0x55, 0xFF with tick every 3rd clk
    tick_div = 3;
    repeat (9) @(negedge clk);
    n = done_times.size();
    exp_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b0});
    exp_q.push_back('{data: 8'hFF, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h55, 1'b0, 1'b1, OS * 3);
    send_frame(8'hFF, 1'b0, 1'b1, OS * 3);
    wait_drain("t6_drain", 300);
    check("t6_done_count", done_times.size() - n, 32'd2);
    if (done_times.size() >= n + 2)
      check("t6_done_spacing", done_times[n + 1] - done_times[n], 32'd528);
    tick_div = 1;
    repeat (10) @(negedge clk);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
